// File: rtl/apb_mem_master_bridge.sv
// apb_mem_master_bridge
// Single-outstanding APB master. It takes one packet from the arbiter,
// runs the APB SETUP/ACCESS handshake, and returns a one-cycle rsp_ack
// with registered read data and error status.
// Optional feature macro: APB_TIMEOUT_EN enables the PREADY watchdog,
// which is bounded by TIMEOUT_CYCLES.
module apb_mem_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  // arbiter side
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  output logic              req_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_ack,
  output logic              rsp_err,
  // APB master side
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              accept;
  logic              complete;
  logic              timeout_hit;

  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              hold_write;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // cnt_q holds the number of earlier stalled ACCESS cycles, so the
  // current stalled cycle reaches the limit when cnt_q == TIMEOUT_CYCLES-1.
  logic [CNT_W-1:0] cnt_q;
`endif

  // Next-state decode and the per-state APB/handshake outputs.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    req_ready   = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY takes priority over the watchdog in the limit cycle
        if (PREADY) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The APB address/data/direction come straight from the holding registers,
  // so they stay stable through ACCESS and keep their last value in IDLE.
  assign PADDR  = hold_addr;
  assign PWDATA = hold_wdata;
  assign PWRITE = hold_write;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted packet on acceptance; ignored while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_write <= 1'b0;
    end else if (accept) begin
      hold_addr  <= req_addr;
      hold_wdata <= req_wdata;
      hold_write <= req_write;
    end
  end

  // Completion response: one-cycle ack, data and error held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_ack   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_ack <= complete | timeout_hit;
      if (complete) begin
        rsp_rdata <= hold_write ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (timeout_hit) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  // Watchdog: cleared on entry to SETUP, advanced on each stalled ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !PREADY && cnt_q != CNT_LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: doc/apb_mem_master_bridge.md
APB_MEM_MASTER_BRIDGE -- requirements
Module: apb_mem_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles spent waiting for PREADY; it is used only with APB_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the arbiter presents a granted packet.
REQ-007 SHALL have ports req_addr (ADDR_W), req_wdata (DATA_W) and req_write (1 bit), all inputs: the packet fields addr, wdata and write.
REQ-008 SHALL have port req_ready, output, 1 bit: the bridge accepts a packet this cycle.
REQ-009 SHALL have port rsp_rdata, output, DATA_W bits: read data returned to the arbiter.
REQ-010 SHALL have port rsp_ack, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_err, output, 1 bit: error status, valid while rsp_ack is high.
REQ-012 SHALL have APB master outputs PADDR (ADDR_W), PWDATA (DATA_W), PWRITE (1), PSEL (1) and PENABLE (1).
REQ-013 SHALL have APB master inputs PRDATA (DATA_W), PREADY (1) and PSLVERR (1).

Function
REQ-014 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-015 In IDLE, req_ready SHALL be 1; in all other states, req_ready SHALL be 0.
REQ-016 In IDLE with req_valid=1, the bridge SHALL capture addr, wdata and write into holding registers and move to SETUP on the next edge.
REQ-017 In SETUP, outputs SHALL be PSEL=1 and PENABLE=0, with PADDR, PWDATA and PWRITE driven from the holding registers; the FSM SHALL move unconditionally to ACCESS.
REQ-018 In ACCESS, outputs SHALL be PSEL=1 and PENABLE=1; PADDR, PWDATA and PWRITE SHALL stay stable until PREADY=1.
REQ-019 In ACCESS with PREADY=1, the bridge SHALL register PRDATA into rsp_rdata for reads or 0 for writes, register PSLVERR into rsp_err, pulse rsp_ack high for exactly the next cycle, and return to IDLE.
REQ-020 Minimum latency SHALL be: acceptance edge N, SETUP in cycle N+1, ACCESS in cycle N+2, and rsp_ack in cycle N+3 when PREADY is high in the first ACCESS cycle.
REQ-021 Each additional PREADY=0 cycle in ACCESS SHALL add exactly one cycle of latency.
REQ-022 Back-to-back operation: during the rsp_ack cycle the FSM SHALL be in IDLE, so a new req_valid SHALL be accepted that same cycle; sustained throughput SHALL be one transfer per 3 cycles.
REQ-023 In IDLE, PSEL and PENABLE SHALL be 0, and PADDR, PWDATA and PWRITE SHALL hold the last captured values.
REQ-024 req_valid while not in IDLE SHALL be ignored, with no capture and no state change.
REQ-025 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-026 rsp_rdata and rsp_err SHALL hold their values until the next completion.

Reset
REQ-027 When reset=0, asynchronously: state SHALL be IDLE; PSEL, PENABLE, PWRITE, rsp_ack and rsp_err SHALL be 0; PADDR, PWDATA, rsp_rdata and the holding registers SHALL be 0; the timeout counter SHALL be 0.
REQ-028 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no rsp_ack.
REQ-029 After reset deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-030 Macro APB_TIMEOUT_EN SHALL control the PREADY watchdog.
REQ-031 With APB_TIMEOUT_EN defined, the bridge SHALL count consecutive ACCESS cycles with PREADY=0; when the count reaches TIMEOUT_CYCLES, it SHALL return to IDLE (PSEL=0, PENABLE=0), set rsp_rdata=0 and rsp_err=1, and pulse rsp_ack for one cycle.
REQ-032 With APB_TIMEOUT_EN defined, the counter SHALL clear on entry to SETUP.
REQ-033 With APB_TIMEOUT_EN defined, PREADY=1 in the same cycle the count reaches its limit SHALL win, giving a normal completion.
REQ-034 With APB_TIMEOUT_EN undefined, the counter SHALL be absent, ACCESS SHALL wait indefinitely for PREADY, and rsp_err SHALL reflect only PSLVERR.

Verification
REQ-035 Read, PREADY tied high: req_valid=1, addr=0x10, write=0 at cycle 0, PRDATA=0xDEADBEEF -> PSEL at cycle 1, PENABLE at cycle 2, rsp_ack at cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-036 Write with 3 wait states: addr=0x20, wdata=0xA5A5A5A5, write=1, PREADY low for 3 ACCESS cycles -> PADDR and PWDATA stable throughout, rsp_ack at cycle 6, rsp_rdata=0.
REQ-037 Slave error: PSLVERR=1 with PREADY -> rsp_err=1 on the ack cycle; the following transfer with PSLVERR=0 -> rsp_err=0.
REQ-038 Back-to-back: req_valid held high with 4 packets -> acceptances at cycles 0, 3, 6 and 9, and exactly 4 rsp_ack pulses.
REQ-039 Reset mid-ACCESS: reset=0 at cycle 2 -> PSEL=0 immediately, no rsp_ack, IDLE on release.
REQ-040 Timeout, with APB_TIMEOUT_EN and TIMEOUT_CYCLES=4: PREADY held 0 -> rsp_ack with rsp_err=1 exactly 4 ACCESS cycles after ACCESS entry, and PSEL deasserted.
